// File: rtl/pool2_sram_writer_pkg.sv
// Shared constants and FSM encoding for the pool2 SRAM writer.
// One frame is 800 signed bytes, packed four per 32-bit word and spread
// round-robin over five SRAM banks of 40 words each.
package pool2_sram_writer_pkg;

    localparam int DATA_WIDTH             = 8;
    localparam int DATA_NUM_PER_SRAM_ADDR = 4;
    localparam int BANK_NUM               = 5;
    localparam int WORD_NUM               = 200;
    localparam int BANK_DEPTH             = WORD_NUM / BANK_NUM;
    localparam int BYTE_NUM               = WORD_NUM * DATA_NUM_PER_SRAM_ADDR;
    localparam int SRAM_ADDR_W            = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/pool2_addr_gen.sv
// Lane / bank / address counters for the pool2 SRAM writer.
// Lane advances on every accepted byte; a lane wrap advances the bank and
// a bank wrap advances the word address. last_o flags the final byte of the
// frame so the writer can finish on the same acceptance.
module pool2_addr_gen
    import pool2_sram_writer_pkg::*;
#(
    parameter int  LANE_NUM = DATA_NUM_PER_SRAM_ADDR,
    parameter int  BANKS    = BANK_NUM,
    parameter int  DEPTH    = BANK_DEPTH,
    localparam int LANE_W   = $clog2(LANE_NUM),
    localparam int BANK_W   = $clog2(BANKS),
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              clear_i,
    input  logic              advance_i,
    output logic [LANE_W-1:0] lane_o,
    output logic [BANK_W-1:0] bank_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    localparam logic [LANE_W-1:0] LANE_MAX = LANE_W'(LANE_NUM - 1);
    localparam logic [BANK_W-1:0] BANK_MAX = BANK_W'(BANKS - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              lane_wrap, bank_wrap, addr_wrap;

    assign lane_wrap = (lane_q == LANE_MAX);
    assign bank_wrap = (bank_q == BANK_MAX);
    assign addr_wrap = (addr_q == ADDR_MAX);

    // Next-state for the cascaded lane -> bank -> address counters.
    always_comb begin
        // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (which would infer a latch).
        lane_d = lane_q;
        bank_d = bank_q;
        addr_d = addr_q;
        if (clear_i) begin
            lane_d = '0;
            bank_d = '0;
            addr_d = '0;
        end else if (advance_i) begin
            lane_d = lane_wrap ? '0 : lane_q + 1'b1;
            if (lane_wrap) begin
                bank_d = bank_wrap ? '0 : bank_q + 1'b1;
                if (bank_wrap) begin
                    addr_d = addr_wrap ? '0 : addr_q + 1'b1;
                end
            end
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values regardless of statement order.
        if (srst) begin
            lane_q <= '0;
            bank_q <= '0;
            addr_q <= '0;
        end else begin
            lane_q <= lane_d;
            bank_q <= bank_d;
            addr_q <= addr_d;
        end
    end

    assign lane_o = lane_q;
    assign bank_o = bank_q;
    assign addr_o = addr_q;
    assign last_o = lane_wrap && bank_wrap && addr_wrap;

endmodule

// File: rtl/pool2_sram_writer.sv
// Pool2 SRAM writer: accepts one signed byte per cycle during a frame and
// turns it into a single-lane, single-bank SRAM write one cycle later.
// The byte is replicated into every lane of the write word; the active-low
// bytemask selects which lane actually lands. The five bank strobe ports
// are fixed, so BANK_NUM is expected to stay at five.
module pool2_sram_writer #(
    parameter int DATA_WIDTH             = pool2_sram_writer_pkg::DATA_WIDTH,
    parameter int DATA_NUM_PER_SRAM_ADDR = pool2_sram_writer_pkg::DATA_NUM_PER_SRAM_ADDR,
    parameter int BANK_NUM               = pool2_sram_writer_pkg::BANK_NUM,
    parameter int WORD_NUM               = pool2_sram_writer_pkg::WORD_NUM
) (
    input  logic                                          clk,
    input  logic                                          srst,
    input  logic                                          start,
    input  logic                                          in_valid,
    input  logic signed [DATA_WIDTH-1:0]                  in_data,
    output logic                                          in_ready,
    output logic                                          sram_write_enable_c0,
    output logic                                          sram_write_enable_c1,
    output logic                                          sram_write_enable_c2,
    output logic                                          sram_write_enable_c3,
    output logic                                          sram_write_enable_c4,
    output logic [DATA_NUM_PER_SRAM_ADDR-1:0]             sram_bytemask_c,
    output logic [pool2_sram_writer_pkg::SRAM_ADDR_W-1:0] sram_waddr_c,
    output logic [DATA_WIDTH*DATA_NUM_PER_SRAM_ADDR-1:0]  sram_wdata_c,
    output logic                                          write_done
);

    import pool2_sram_writer_pkg::*;

    localparam int LANE_N  = DATA_NUM_PER_SRAM_ADDR;
    localparam int DEPTH   = WORD_NUM / BANK_NUM;
    localparam int LANE_W  = $clog2(LANE_N);
    localparam int BANK_W  = $clog2(BANK_NUM);
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int WDATA_W = DATA_WIDTH * LANE_N;

    localparam logic [BANK_NUM-1:0] BANK_ONE = BANK_NUM'(1);
    localparam logic [LANE_N-1:0]   LANE_MSB = {1'b1, {(LANE_N - 1){1'b0}}};

    state_e                 state_q;
    logic [BANK_NUM-1:0]    we_n_q, we_n_d;
    logic [LANE_N-1:0]      mask_q, mask_d;
    logic [SRAM_ADDR_W-1:0] waddr_q, waddr_d;
    logic [WDATA_W-1:0]     wdata_q, wdata_d;
    logic                   write_done_q;

    logic                   accept;
    logic                   frame_start;
    logic [LANE_W-1:0]      lane;
    logic [BANK_W-1:0]      bank;
    logic [ADDR_W-1:0]      addr;
    logic                   last_byte;

    assign in_ready    = (state_q == ST_WRITE);
    assign accept      = in_valid && in_ready;
    assign frame_start = (state_q == ST_IDLE) && start;

    pool2_addr_gen #(
        .LANE_NUM (LANE_N),
        .BANKS    (BANK_NUM),
        .DEPTH    (DEPTH)
    ) u_addr_gen (
        .clk       (clk),
        .srst      (srst),
        .clear_i   (frame_start),
        .advance_i (accept),
        .lane_o    (lane),
        .bank_o    (bank),
        .addr_o    (addr),
        .last_o    (last_byte)
    );

    // Write word for the byte being accepted this cycle: one bank strobe,
    // one lane cleared in the mask (lane 0 is the MSB lane), byte replicated.
    always_comb begin
        we_n_d  = ~(BANK_ONE << bank);
        mask_d  = ~(LANE_MSB >> lane);
        waddr_d = SRAM_ADDR_W'(addr);
        wdata_d = {LANE_N{in_data}};
    end

    // Frame FSM and registered SRAM write port; strobes default to idle
    // every cycle so a write lasts exactly one cycle per accepted byte.
    always_ff @(posedge clk) begin
        if (srst) begin
            state_q      <= ST_IDLE;
            we_n_q       <= '1;
            mask_q       <= '1;
            waddr_q      <= '0;
            wdata_q      <= '0;
            write_done_q <= 1'b0;
        end else begin
            we_n_q       <= '1;
            mask_q       <= '1;
            write_done_q <= 1'b0;
            if (accept) begin
                we_n_q  <= we_n_d;
                mask_q  <= mask_d;
                waddr_q <= waddr_d;
                wdata_q <= wdata_d;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (start) state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (accept && last_byte) begin
                        state_q      <= ST_DONE;
                        write_done_q <= 1'b1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign sram_write_enable_c0 = we_n_q[0];
    assign sram_write_enable_c1 = we_n_q[1];
    assign sram_write_enable_c2 = we_n_q[2];
    assign sram_write_enable_c3 = we_n_q[3];
    assign sram_write_enable_c4 = we_n_q[4];
    assign sram_bytemask_c      = mask_q;
    assign sram_waddr_c         = waddr_q;
    assign sram_wdata_c         = wdata_q;
    assign write_done           = write_done_q;

endmodule

// File: tb/tb_pool2_sram_writer.sv
// Self-checking bench for pool2_sram_writer. A byte-index model (n -> word
// n/4, lane n%4, bank (n/4)%5, address n/20) predicts every cycle's write
// port, and a behavioural SRAM built from the DUT strobes is compared with
// the image the model expects at the end of each frame.
module tb_pool2_sram_writer;

    logic              clk = 1'b0;
    logic              srst;
    logic              start;
    logic              in_valid;
    logic signed [7:0] in_data;
    logic              in_ready;
    logic              we_c0, we_c1, we_c2, we_c3, we_c4;
    logic [3:0]        bytemask;
    logic [9:0]        waddr;
    logic [31:0]       wdata;
    logic              write_done;
    logic [4:0]        we_obs;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    bit m_active = 1'b0;
    bit m_done   = 1'b0;
    int m_n      = 0;

    // Observation counters and memories.
    int          writes_seen = 0;
    int          done_seen   = 0;
    int          ready_seen  = 0;
    logic [31:0] sram    [5][40];
    logic [31:0] exp_img [5][40];

    always #5 clk = ~clk;

    assign we_obs = {we_c4, we_c3, we_c2, we_c1, we_c0};

    pool2_sram_writer dut (
        .clk                  (clk),
        .srst                 (srst),
        .start                (start),
        .in_valid             (in_valid),
        .in_data              (in_data),
        .in_ready             (in_ready),
        .sram_write_enable_c0 (we_c0),
        .sram_write_enable_c1 (we_c1),
        .sram_write_enable_c2 (we_c2),
        .sram_write_enable_c3 (we_c3),
        .sram_write_enable_c4 (we_c4),
        .sram_bytemask_c      (bytemask),
        .sram_waddr_c         (waddr),
        .sram_wdata_c         (wdata),
        .write_done           (write_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check the registered write port against
    // the model, advance the model, and apply any DUT write to the SRAM copy.
    task automatic step(input logic rst, input logic st, input logic vld, input logic [7:0] dat);
        bit         acc;
        int         k, i, j;
        logic [4:0] exp_we;
        logic [3:0] exp_mask;
        bit         prev_done;
        @(negedge clk);
        srst     = rst;
        start    = st;
        in_valid = vld;
        in_data  = dat;
        #1;
        check("in_ready", in_ready, m_active);
        if (in_ready === 1'b1) ready_seen++;
        acc = !rst && m_active && vld;
        k = (m_n / 4) % 5;
        i = m_n / 20;
        j = m_n % 4;
        exp_we = 5'h1F;
        exp_we[k] = 1'b0;
        exp_mask = 4'hF;
        exp_mask[3 - j] = 1'b0;
        @(posedge clk);
        #1;
        if (rst) begin
            check("rst_we", we_obs, 5'h1F);
            check("rst_mask", bytemask, 4'hF);
            check("rst_waddr", waddr, 0);
            check("rst_wdata", wdata, 0);
            check("rst_done", write_done, 0);
        end else if (acc) begin
            check("wr_we", we_obs, exp_we);
            check("wr_mask", bytemask, exp_mask);
            check("wr_waddr", waddr, i);
            check("wr_wdata", wdata, {4{dat}});
            check("wr_done", write_done, m_n == 799);
            if (m_n == 20) begin
                check("b20_we", we_obs, 5'h1E);
                check("b20_waddr", waddr, 1);
                check("b20_mask", bytemask, 4'b0111);
            end
            exp_img[k][i][31 - 8 * j -: 8] = dat;
        end else begin
            check("idle_we", we_obs, 5'h1F);
            check("idle_mask", bytemask, 4'hF);
            check("idle_done", write_done, 0);
        end
        // Model update: frame flag, DONE cycle and byte index.
        prev_done = m_done;
        m_done = 1'b0;
        if (rst) begin
            m_active = 1'b0;
            m_n = 0;
        end else if (m_active) begin
            if (acc) begin
                m_n++;
                if (m_n == 800) begin
                    m_active = 1'b0;
                    m_done = 1'b1;
                    m_n = 0;
                end
            end
        end else if (!prev_done && st) begin
            m_active = 1'b1;
            m_n = 0;
        end
        // Behavioural SRAM driven by the DUT strobes.
        if (we_obs !== 5'h1F) writes_seen++;
        if (write_done === 1'b1) done_seen++;
        for (int b = 0; b < 5; b++) begin
            if (we_obs[b] === 1'b0 && waddr < 40) begin
                for (int l = 0; l < 4; l++) begin
                    if (bytemask[3 - l] === 1'b0)
                        sram[b][waddr][31 - 8 * l -: 8] = wdata[31 - 8 * l -: 8];
                end
            end
        end
    endtask

    // Full frame. mode 0: back-to-back, 1: valid on odd cycles, 2: random
    // valid and data. Sequential modes carry byte n%256 and stray starts.
    task automatic run_frame(input int mode);
        int w0, d0, r0;
        bit vld, st;
        logic [7:0] dat;
        w0 = writes_seen;
        d0 = done_seen;
        step(1'b0, 1'b1, 1'b0, 8'h00);
        r0 = ready_seen;
        for (int c = 0; c < 4000 && (m_active || m_done); c++) begin
            case (mode)
                0:       vld = 1'b1;
                1:       vld = (c % 2) == 1;
                default: vld = $urandom_range(0, 3) != 0;
            endcase
            dat = (mode == 2) ? 8'($urandom) : 8'(m_n % 256);
            st  = (mode != 2) && (c % 131 == 7);
            step(1'b0, st, vld, dat);
        end
        check("frame_writes", writes_seen - w0, 800);
        check("frame_done_pulses", done_seen - d0, 1);
        if (mode == 0) check("frame_ready_cycles", ready_seen - r0, 800);
        if (mode == 1) check("frame_ready_cycles", ready_seen - r0, 1600);
        check("idle_after_frame", in_ready, 0);
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 40; i++) begin
                logic [31:0] w;
                for (int j = 0; j < 4; j++) w[31 - 8 * j -: 8] = 8'((20 * i + 4 * k + j) % 256);
                check("img_model", sram[k][i], exp_img[k][i]);
                if (mode != 2) check("img_formula", sram[k][i], w);
            end
        end
    endtask

    initial begin
        int w_abort;
        for (int k = 0; k < 5; k++)
            for (int i = 0; i < 40; i++) begin
                sram[k][i] = '0;
                exp_img[k][i] = '0;
            end
        srst = 1'b1;
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", in_ready, 0);
        check("reset_we", we_obs, 5'h1F);
        check("reset_mask", bytemask, 4'hF);
        check("reset_waddr", waddr, 0);
        check("reset_wdata", wdata, 0);
        check("reset_done", write_done, 0);

        // Bytes offered in IDLE are never taken.
        repeat (5) step(1'b0, 1'b0, 1'b1, 8'($urandom));
        check("idle_no_writes", writes_seen, 0);

        // Reset wins over start and in_valid in the same cycle.
        step(1'b1, 1'b1, 1'b1, 8'h55);
        step(1'b0, 1'b0, 1'b1, 8'h11);
        check("rst_prio_ready", in_ready, 0);

        // Frame aborted by reset after 300 bytes; first byte is 8'h7F.
        step(1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h7F);
        check("b0_we", we_obs, 5'h1E);
        check("b0_waddr", waddr, 0);
        check("b0_mask", bytemask, 4'b0111);
        check("b0_wdata", wdata, 32'h7F7F7F7F);
        for (int c = 0; c < 1000 && m_n < 300; c++) step(1'b0, 1'b0, 1'b1, 8'($urandom));
        w_abort = writes_seen;
        step(1'b1, 1'b1, 1'b1, 8'hAA);
        repeat (10) step(1'b0, 1'b0, 1'b1, 8'($urandom));
        check("no_write_after_srst", writes_seen - w_abort, 0);

        run_frame(0);
        run_frame(1);
        run_frame(2);
        repeat (4) step(1'b0, 1'b0, 1'b1, 8'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
